quality_sort_ctrl: RTL and testbench
====================================

QUALITY_SORT_CTRL -- requirements
Module: quality_sort_ctrl

Interface
REQ-001 SHALL have parameter BATCH, default 10: number of items graded per batch, legal range 1..255.
REQ-002 SHALL have parameter REJ_LIM, default 3: number of consecutive rejects that raises alarm, legal range 1..255.
REQ-003 SHALL have parameter CNT_W, default 8: width of each per-grade counter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous assertion and active-low.
REQ-006 SHALL have port start, input, 1 bit: pulse that begins a batch.
REQ-007 SHALL have port item_valid, input, 1 bit: the test results a/b/c are valid.
REQ-008 SHALL have port item_ready, output, 1 bit: the controller accepts an item.
REQ-009 SHALL have ports a, b, c, input, 1 bit each: results of the three tests (1 = pass); a is the primary test.
REQ-010 SHALL have port grade_valid, output, 1 bit: grade is valid this cycle.
REQ-011 SHALL have port grade, output, 2 bits: grade code (see REQ-016).
REQ-012 SHALL have ports cnt_g1, cnt_g2, cnt_g3, cnt_rej, output, CNT_W bits each: per-grade tallies for the current batch.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-014 SHALL have port batch_done, output, 1 bit: one-cycle pulse at the end of a batch.
REQ-015 SHALL have port alarm, output, 1 bit: sticky reject-streak alarm.

Function
REQ-016 SHALL grade items by priority:
 - a&b&c -> 2'b11 (G1)
 - else a&(b|c) -> 2'b10 (G2)
 - else ~a&b&c -> 2'b01 (G3)
 - else -> 2'b00 (reject)
REQ-017 SHALL implement the FSM states IDLE, ACCEPT, GRADE, DONE.
REQ-018 IDLE: item_ready=0; when start=1, SHALL go to ACCEPT and in the same edge clear all counters, the item count, the streak count and alarm.
REQ-019 ACCEPT: item_ready=1; a handshake occurs when item_valid&item_ready; on handshake SHALL register a/b/c, increment the item count and go to GRADE; with no handshake SHALL stay in ACCEPT.
REQ-020 GRADE: item_ready=0; grade_valid=1 for exactly one cycle with the registered grade, so latency is 1 cycle after the handshake edge and maximum throughput is one item per 2 cycles.
REQ-021 GRADE: SHALL increment the matching counter at the exit edge; counters saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-022 GRADE: a reject increments the streak count (saturating); any non-reject clears it to 0.
REQ-023 GRADE: alarm SHALL set when the updated streak count reaches REJ_LIM; alarm stays set until the next accepted start or reset.
REQ-024 GRADE -> DONE when the item count equals BATCH, else GRADE -> ACCEPT.
REQ-025 DONE: batch_done=1 for one cycle, then go to IDLE; counters and alarm SHALL hold their values in IDLE.
REQ-026 start SHALL be ignored in every state except IDLE.
REQ-027 item_valid SHALL be ignored outside ACCEPT, and a/b/c SHALL be sampled only on a handshake.
REQ-028 grade SHALL hold its last value when grade_valid=0.

Reset
REQ-029 When rst_n=0, SHALL immediately force: state IDLE; item_ready, grade_valid, busy, batch_done, alarm = 0; grade = 2'b00; all counters, the item count and the streak count = 0.
REQ-030 Reset asserted mid-batch SHALL abandon the batch with no batch_done pulse.
REQ-031 After reset is released, SHALL wait in IDLE for start.

Verification
REQ-032 Scenario 1: BATCH=4, start, then items abc = 111, 101, 011, 000 each presented with item_valid held high -> grades 11, 10, 01, 00, each grade 1 cycle after its handshake; final cnt_g1 = cnt_g2 = cnt_g3 = cnt_rej = 1; one batch_done pulse; alarm = 0.
REQ-033 Scenario 2: REJ_LIM=3, items 000, 100, 001 -> alarm rises at the GRADE exit of the 3rd item; a following item 111 leaves alarm = 1; the next start clears alarm.
REQ-034 Scenario 3: items 000, 000, 110, 000, 000 with REJ_LIM=3 -> streak is broken by the 110 item, alarm stays 0, cnt_rej = 4.
REQ-035 Scenario 4: CNT_W=2, BATCH=6, all items 111 -> cnt_g1 saturates at 3 with no wrap.
REQ-036 Scenario 5: start pulsed during ACCEPT and during GRADE -> no effect on state or counters; item_valid stalled low for 5 cycles -> FSM stays in ACCEPT with item_ready = 1.
REQ-037 Scenario 6: rst_n driven low asynchronously (between clock edges) after 2 of 4 items -> all outputs go to 0 immediately and no batch_done pulse occurs; a new start then runs a full batch cleanly.

Source files
------------

// File: rtl/quality_sort_ctrl.sv
// Three-test quality grader with per-batch tallies.
// Also raises a sticky alarm on a run of consecutive rejects.
module quality_sort_ctrl #(
   parameter int BATCH   = 10,
   parameter int REJ_LIM = 3,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             item_valid,
   output logic             item_ready,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   output logic             grade_valid,
   output logic [1:0]       grade,
   output logic [CNT_W-1:0] cnt_g1,
   output logic [CNT_W-1:0] cnt_g2,
   output logic [CNT_W-1:0] cnt_g3,
   output logic [CNT_W-1:0] cnt_rej,
   output logic             busy,
   output logic             batch_done,
   output logic             alarm
);

   typedef enum logic [1:0] {
      IDLE,
      ACCEPT,
      GRADE,
      DONE
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic       hs;
   logic [1:0] grade_d;
   logic [7:0] item_cnt;
   logic [7:0] streak;
   logic [7:0] streak_inc;
   logic       last_item;

   function automatic logic [CNT_W-1:0] sat_inc(
      input logic [CNT_W-1:0] v
   );
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign hs         = item_valid & item_ready;
   assign last_item  = (item_cnt == 8'(BATCH));
   assign streak_inc = (&streak) ? streak : streak + 8'd1;

   // Terms are made disjoint so the priority order needs no chain.
   always_comb begin
      grade_d = 2'b00;
      unique case (1'b1)
         (a & b & c):  grade_d = 2'b11;
         (a & (b ^ c)): grade_d = 2'b10;
         (~a & b & c): grade_d = 2'b01;
         default:      grade_d = 2'b00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = ACCEPT;
         ACCEPT:  if (hs) state_nxt = GRADE;
         GRADE:   state_nxt = last_item ? DONE : ACCEPT;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      item_ready  = (state == ACCEPT);
      grade_valid = (state == GRADE);
      busy        = (state != IDLE);
      batch_done  = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grade    <= 2'b00;
         item_cnt <= '0;
         streak   <= '0;
         alarm    <= 1'b0;
         cnt_g1   <= '0;
         cnt_g2   <= '0;
         cnt_g3   <= '0;
         cnt_rej  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  item_cnt <= '0;
                  streak   <= '0;
                  alarm    <= 1'b0;
                  cnt_g1   <= '0;
                  cnt_g2   <= '0;
                  cnt_g3   <= '0;
                  cnt_rej  <= '0;
               end
            end
            ACCEPT: begin
               if (hs) begin
                  grade    <= grade_d;
                  item_cnt <= item_cnt + 8'd1;
               end
            end
            GRADE: begin
               unique case (grade)
                  2'b11: begin
                     cnt_g1 <= sat_inc(cnt_g1);
                     streak <= '0;
                  end
                  2'b10: begin
                     cnt_g2 <= sat_inc(cnt_g2);
                     streak <= '0;
                  end
                  2'b01: begin
                     cnt_g3 <= sat_inc(cnt_g3);
                     streak <= '0;
                  end
                  default: begin
                     cnt_rej <= sat_inc(cnt_rej);
                     streak  <= streak_inc;
                     if (streak_inc >= 8'(REJ_LIM))
                        alarm <= 1'b1;
                  end
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_quality_sort_ctrl.sv
// Bench for quality_sort_ctrl: three configurations,
// event-level reference model and directed scenarios.
module tb_quality_sort_ctrl;

   localparam int NB[3] = '{4, 5, 6};
   localparam int NW[3] = '{8, 8, 2};
   localparam int REJ   = 3;

   logic       clk;
   logic       rst_n;
   logic [2:0] start_v;
   logic [2:0] iv_v;
   logic [2:0] a_v;
   logic [2:0] b_v;
   logic [2:0] c_v;
   logic [2:0] ready_v;
   logic [2:0] gv_v;
   logic [2:0] busy_v;
   logic [2:0] done_v;
   logic [2:0] alarm_v;
   logic [1:0] grade_v [3];
   logic [7:0] cg1_v [3];
   logic [7:0] cg2_v [3];
   logic [7:0] cg3_v [3];
   logic [7:0] crj_v [3];

   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int W = NW[g];
      logic [W-1:0] c1;
      logic [W-1:0] c2;
      logic [W-1:0] c3;
      logic [W-1:0] cr;
      logic [1:0]   gr;
      quality_sort_ctrl #(
         .BATCH(NB[g]), .REJ_LIM(REJ), .CNT_W(W)
      ) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .start      (start_v[g]),
         .item_valid (iv_v[g]),
         .item_ready (ready_v[g]),
         .a          (a_v[g]),
         .b          (b_v[g]),
         .c          (c_v[g]),
         .grade_valid(gv_v[g]),
         .grade      (gr),
         .cnt_g1     (c1),
         .cnt_g2     (c2),
         .cnt_g3     (c3),
         .cnt_rej    (cr),
         .busy       (busy_v[g]),
         .batch_done (done_v[g]),
         .alarm      (alarm_v[g])
      );
      assign grade_v[g] = gr;
      assign cg1_v[g]   = 8'(c1);
      assign cg2_v[g]   = 8'(c2);
      assign cg3_v[g]   = 8'(c3);
      assign crj_v[g]   = 8'(cr);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int grade_of(input bit ta, input bit tb, input bit tc);
      if (ta && tb && tc) return 3;
      if (ta && (tb || tc)) return 2;
      if (!ta && tb && tc) return 1;
      return 0;
   endfunction

   // Model state: tally index 3=G1, 2=G2, 1=G3, 0=reject
   int cmax[3] = '{255, 255, 3};
   int m_busy[3];
   int hs_p[3];
   int done_e[3];
   int items[3];
   int streak[3];
   int m_alarm[3];
   int last_g[3];
   int pend[3];
   int done_cnt[3];
   int tally[3][4];

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) begin
            chk($sformatf("d%0d rst busy", i), busy_v[i], 0);
            chk($sformatf("d%0d rst ready", i), ready_v[i], 0);
            chk($sformatf("d%0d rst gv", i), gv_v[i], 0);
            chk($sformatf("d%0d rst grade", i), grade_v[i], 0);
            chk($sformatf("d%0d rst done", i), done_v[i], 0);
            chk($sformatf("d%0d rst alarm", i), alarm_v[i], 0);
            chk($sformatf("d%0d rst g1", i), cg1_v[i], 0);
            chk($sformatf("d%0d rst rej", i), crj_v[i], 0);
            m_busy[i] = 0; hs_p[i] = 0; done_e[i] = 0;
            items[i] = 0; streak[i] = 0; m_alarm[i] = 0;
            last_g[i] = 0; pend[i] = 0;
            for (int k = 0; k < 4; k++) tally[i][k] = 0;
         end else begin
            int  exp_rdy;
            int  n_hs;
            int  n_done;
            int  was_busy;
            int  gd;
            exp_rdy = (m_busy[i] != 0 && hs_p[i] == 0 &&
                       done_e[i] == 0) ? 1 : 0;
            chk($sformatf("d%0d ready", i), ready_v[i], exp_rdy);
            chk($sformatf("d%0d gv", i), gv_v[i], hs_p[i]);
            chk($sformatf("d%0d grade", i), grade_v[i],
                hs_p[i] != 0 ? pend[i] : last_g[i]);
            chk($sformatf("d%0d busy", i), busy_v[i], m_busy[i]);
            chk($sformatf("d%0d done", i), done_v[i], done_e[i]);
            chk($sformatf("d%0d alarm", i), alarm_v[i], m_alarm[i]);
            chk($sformatf("d%0d g1", i), cg1_v[i], tally[i][3]);
            chk($sformatf("d%0d g2", i), cg2_v[i], tally[i][2]);
            chk($sformatf("d%0d g3", i), cg3_v[i], tally[i][1]);
            chk($sformatf("d%0d rej", i), crj_v[i], tally[i][0]);
            if (done_v[i]) done_cnt[i]++;
            was_busy = m_busy[i];
            n_done = 0;
            if (hs_p[i] != 0) begin
               gd = pend[i];
               last_g[i] = gd;
               if (tally[i][gd] < cmax[i]) tally[i][gd]++;
               if (gd == 0) begin
                  if (streak[i] < 255) streak[i]++;
                  if (streak[i] >= REJ) m_alarm[i] = 1;
               end else begin
                  streak[i] = 0;
               end
               if (items[i] == NB[i]) n_done = 1;
            end
            if (done_e[i] != 0) m_busy[i] = 0;
            n_hs = (exp_rdy != 0 && iv_v[i]) ? 1 : 0;
            if (n_hs != 0) begin
               pend[i] = grade_of(a_v[i], b_v[i], c_v[i]);
               items[i]++;
            end
            if (start_v[i] && was_busy == 0) begin
               m_busy[i] = 1; items[i] = 0;
               streak[i] = 0; m_alarm[i] = 0;
               for (int k = 0; k < 4; k++) tally[i][k] = 0;
            end
            hs_p[i] = n_hs;
            done_e[i] = n_done;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int i);
      start_v[i] = 1'b1;
      tick();
      start_v[i] = 1'b0;
   endtask

   task automatic send(input int i, input bit [2:0] abc);
      a_v[i] = abc[2];
      b_v[i] = abc[1];
      c_v[i] = abc[0];
      iv_v[i] = 1'b1;
      for (int k = 0; k < 20 && !ready_v[i]; k++) tick();
      chk($sformatf("d%0d send wait", i), ready_v[i], 1);
      if (ready_v[i]) tick();
      iv_v[i] = 1'b0;
   endtask

   task automatic wait_idle(input int i);
      for (int k = 0; k < 50 && busy_v[i]; k++) tick();
      chk($sformatf("d%0d idle wait", i), busy_v[i], 0);
   endtask

   initial begin
      int dc;
      rst_n = 1'b0;
      start_v = '0; iv_v = '0;
      a_v = '0; b_v = '0; c_v = '0;
      #2;
      chk("reset busy", busy_v[0], 0);
      chk("reset grade", grade_v[0], 0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Scenario 1: one item of each grade
      do_start(0);
      send(0, 3'b111);
      chk("s1 grade g1", grade_v[0], 3);
      send(0, 3'b101);
      chk("s1 grade g2", grade_v[0], 2);
      send(0, 3'b011);
      chk("s1 grade g3", grade_v[0], 1);
      send(0, 3'b000);
      chk("s1 grade rej", grade_v[0], 0);
      wait_idle(0);
      chk("s1 g1", cg1_v[0], 1);
      chk("s1 g2", cg2_v[0], 1);
      chk("s1 g3", cg3_v[0], 1);
      chk("s1 rej", crj_v[0], 1);
      chk("s1 alarm", alarm_v[0], 0);
      chk("s1 done pulses", done_cnt[0], 1);

      // Scenario 2: reject streak raises sticky alarm
      do_start(0);
      send(0, 3'b000);
      send(0, 3'b100);
      send(0, 3'b001);
      chk("s2 alarm before exit", alarm_v[0], 0);
      tick();
      chk("s2 alarm after exit", alarm_v[0], 1);
      send(0, 3'b111);
      wait_idle(0);
      chk("s2 alarm held idle", alarm_v[0], 1);
      chk("s2 rej", crj_v[0], 3);
      do_start(0);
      chk("s2 alarm cleared", alarm_v[0], 0);
      chk("s2 rej cleared", crj_v[0], 0);
      for (int k = 0; k < 4; k++) send(0, 3'b111);
      wait_idle(0);

      // Scenario 3: streak broken
      do_start(1);
      send(1, 3'b000);
      send(1, 3'b000);
      send(1, 3'b110);
      send(1, 3'b000);
      send(1, 3'b000);
      wait_idle(1);
      chk("s3 alarm", alarm_v[1], 0);
      chk("s3 rej", crj_v[1], 4);
      chk("s3 g2", cg2_v[1], 1);

      // Scenario 4: 2-bit counter saturation
      do_start(2);
      for (int k = 0; k < 6; k++) send(2, 3'b111);
      wait_idle(2);
      chk("s4 g1 sat", cg1_v[2], 3);
      chk("s4 done pulses", done_cnt[2], 1);

      // Scenario 5: stray start and stalled item_valid
      do_start(0);
      for (int k = 0; k < 5; k++) begin
         chk("s5 stall ready", ready_v[0], 1);
         tick();
      end
      send(0, 3'b111);
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      chk("s5 g1 kept", cg1_v[0], 1);
      send(0, 3'b110);
      send(0, 3'b010);
      send(0, 3'b000);
      wait_idle(0);
      chk("s5 g1", cg1_v[0], 1);
      chk("s5 g2", cg2_v[0], 1);
      chk("s5 rej", crj_v[0], 2);

      // Scenario 6: async reset mid-batch
      dc = done_cnt[0];
      do_start(0);
      send(0, 3'b111);
      send(0, 3'b101);
      #2;
      rst_n = 1'b0;
      #1;
      chk("s6 busy", busy_v[0], 0);
      chk("s6 gv", gv_v[0], 0);
      chk("s6 ready", ready_v[0], 0);
      chk("s6 grade", grade_v[0], 0);
      chk("s6 g1", cg1_v[0], 0);
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick();
      chk("s6 no done", done_cnt[0], dc);
      do_start(0);
      send(0, 3'b111);
      send(0, 3'b111);
      send(0, 3'b011);
      send(0, 3'b000);
      wait_idle(0);
      chk("s6 new done", done_cnt[0], dc + 1);
      chk("s6 new g1", cg1_v[0], 2);
      chk("s6 new g3", cg3_v[0], 1);
      tick();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
